// File: rtl/rtc_time_loader_if.sv
// Bundle between the time-set receiver and its surroundings: the serial
// line into the loader and the BCD time fields / strobes coming out of it.
interface rtc_time_loader_if;
    logic       rxd;
    logic [1:0] hr1;
    logic [3:0] hr0;
    logic [2:0] min1;
    logic [3:0] min0;
    logic [2:0] sec1;
    logic [3:0] sec0;
    logic       load;
    logic       err;
    logic       busy;

    // Loader side: consumes the line, produces the time fields.
    modport slave (
        input  rxd,
        output hr1, hr0, min1, min0, sec1, sec0, load, err, busy
    );

    // Host side: drives the line, observes the time fields.
    modport master (
        output rxd,
        input  hr1, hr0, min1, min0, sec1, sec0, load, err, busy
    );
endinterface

// File: rtl/rtc_time_loader.sv
// Serial time-set receiver: UART 8N1 bytes forming "HH:MM:SS" + CR/LF are
// checked against 24-hour limits and handed to the RTC as BCD digits with
// a one-cycle load strobe. Framing and format errors give a one-cycle err.
module rtc_time_loader #(
    parameter int unsigned BAUD_DIV    = 27,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    rtc_time_loader_if.slave bus
);

    localparam int unsigned SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int unsigned CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] TC = CW'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP,
        R_WAIT_HIGH
    } r_state_t;

    typedef enum logic [3:0] {
        P_H1,
        P_H0,
        P_C1,
        P_M1,
        P_M0,
        P_C2,
        P_S1,
        P_S0,
        P_END
    } p_state_t;

    logic [SS-1:0] sync_q;
    logic          rxd_s;
    logic [CW-1:0] tick_cnt;
    logic          tick;
    logic          start_det;

    r_state_t      rstate;
    logic [3:0]    phase;
    logic [2:0]    bit_cnt;
    logic [7:0]    data_q;
    logic          byte_valid;
    logic          frame_err;

    p_state_t      pstate;
    logic [1:0]    h1_s;
    logic [3:0]    h0_s;
    logic [2:0]    m1_s;
    logic [3:0]    m0_s;
    logic [2:0]    s1_s;
    logic [3:0]    s0_s;

    logic [1:0]    hr1_q;
    logic [3:0]    hr0_q;
    logic [2:0]    min1_q;
    logic [3:0]    min0_q;
    logic [2:0]    sec1_q;
    logic [3:0]    sec0_q;
    logic          load_q;
    logic          err_q;

    logic          is_digit;
    logic          is_eol;
    logic          is_colon;
    logic [3:0]    dval;

    // Synchronizer for the asynchronous line; resets to idle-high so no
    // false start bit is seen coming out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SS-2:0], bus.rxd};
        end
    end

    assign rxd_s     = sync_q[SS-1];
    assign start_det = (rstate == R_IDLE) && !rxd_s;
    assign tick      = (tick_cnt == TC);

    // Free-running oversample tick; realigned to the falling start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (start_det || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Receiver FSM: mid-bit sampling of start, 8 data bits LSB first, stop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rstate     <= R_IDLE;
            phase      <= '0;
            bit_cnt    <= '0;
            data_q     <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rstate)
                R_IDLE: begin
                    if (!rxd_s) begin
                        rstate <= R_START;
                        phase  <= '0;
                    end
                end
                R_START: begin
                    if (tick) begin
                        if (phase == 4'd7) begin
                            phase   <= '0;
                            bit_cnt <= '0;
                            rstate  <= rxd_s ? R_IDLE : R_DATA;
                        end else begin
                            phase <= phase + 1'b1;
                        end
                    end
                end
                R_DATA: begin
                    if (tick) begin
                        if (phase == 4'd15) begin
                            phase   <= '0;
                            data_q  <= {rxd_s, data_q[7:1]};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 3'd7) begin
                                rstate <= R_STOP;
                            end
                        end else begin
                            phase <= phase + 1'b1;
                        end
                    end
                end
                R_STOP: begin
                    if (tick) begin
                        if (phase == 4'd15) begin
                            phase <= '0;
                            if (rxd_s) begin
                                byte_valid <= 1'b1;
                                rstate     <= R_IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                rstate    <= R_WAIT_HIGH;
                            end
                        end else begin
                            phase <= phase + 1'b1;
                        end
                    end
                end
                R_WAIT_HIGH: begin
                    if (rxd_s) begin
                        rstate <= R_IDLE;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    assign is_digit = (data_q >= 8'h30) && (data_q <= 8'h39);
    assign is_eol   = (data_q == 8'h0D) || (data_q == 8'h0A);
    assign is_colon = (data_q == 8'h3A);
    assign dval     = data_q[3:0];

    // Parser FSM: validates each field into shadow digits, then commits all
    // six digits together with load when the line terminator arrives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pstate <= P_H1;
            h1_s   <= '0;
            h0_s   <= '0;
            m1_s   <= '0;
            m0_s   <= '0;
            s1_s   <= '0;
            s0_s   <= '0;
            hr1_q  <= '0;
            hr0_q  <= '0;
            min1_q <= '0;
            min0_q <= '0;
            sec1_q <= '0;
            sec0_q <= '0;
            load_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            load_q <= 1'b0;
            err_q  <= 1'b0;
            if (frame_err) begin
                pstate <= P_H1;
                err_q  <= 1'b1;
            end else if (byte_valid) begin
                case (pstate)
                    P_H1: begin
                        if (!is_eol) begin
                            if (is_digit && (dval <= 4'd2)) begin
                                h1_s   <= dval[1:0];
                                pstate <= P_H0;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    P_H0: begin
                        if (is_digit && ((h1_s != 2'd2) || (dval <= 4'd3))) begin
                            h0_s   <= dval;
                            pstate <= P_C1;
                        end else begin
                            err_q  <= 1'b1;
                            pstate <= P_H1;
                        end
                    end
                    P_C1: begin
                        if (is_colon) begin
                            pstate <= P_M1;
                        end else begin
                            err_q  <= 1'b1;
                            pstate <= P_H1;
                        end
                    end
                    P_M1: begin
                        if (is_digit && (dval <= 4'd5)) begin
                            m1_s   <= dval[2:0];
                            pstate <= P_M0;
                        end else begin
                            err_q  <= 1'b1;
                            pstate <= P_H1;
                        end
                    end
                    P_M0: begin
                        if (is_digit) begin
                            m0_s   <= dval;
                            pstate <= P_C2;
                        end else begin
                            err_q  <= 1'b1;
                            pstate <= P_H1;
                        end
                    end
                    P_C2: begin
                        if (is_colon) begin
                            pstate <= P_S1;
                        end else begin
                            err_q  <= 1'b1;
                            pstate <= P_H1;
                        end
                    end
                    P_S1: begin
                        if (is_digit && (dval <= 4'd5)) begin
                            s1_s   <= dval[2:0];
                            pstate <= P_S0;
                        end else begin
                            err_q  <= 1'b1;
                            pstate <= P_H1;
                        end
                    end
                    P_S0: begin
                        if (is_digit) begin
                            s0_s   <= dval;
                            pstate <= P_END;
                        end else begin
                            err_q  <= 1'b1;
                            pstate <= P_H1;
                        end
                    end
                    P_END: begin
                        if (is_eol) begin
                            hr1_q  <= h1_s;
                            hr0_q  <= h0_s;
                            min1_q <= m1_s;
                            min0_q <= m0_s;
                            sec1_q <= s1_s;
                            sec0_q <= s0_s;
                            load_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                        pstate <= P_H1;
                    end
                    default: pstate <= P_H1;
                endcase
            end
        end
    end

    assign bus.hr1  = hr1_q;
    assign bus.hr0  = hr0_q;
    assign bus.min1 = min1_q;
    assign bus.min0 = min0_q;
    assign bus.sec1 = sec1_q;
    assign bus.sec0 = sec0_q;
    assign bus.load = load_q;
    assign bus.err  = err_q;
    assign bus.busy = (rstate != R_IDLE) || (pstate != P_H1);

endmodule

// File: tb/tb_rtc_time_loader.sv
// Directed bench for rtc_time_loader: table of time strings with expected
// load/err counts and resulting digits, plus hand sequences for glitches,
// break conditions, framing errors and mid-string reset.
module tb_rtc_time_loader;

    localparam int BAUD = 4;
    localparam int BIT  = 16 * BAUD;

    logic clk = 1'b0;
    logic rst = 1'b0;

    rtc_time_loader_if bus ();

    rtc_time_loader #(
        .BAUD_DIV    (BAUD),
        .SYNC_STAGES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    int load_total    = 0;
    int err_total     = 0;
    int overlap_total = 0;

    // Pulse counters observed away from the active edge.
    always @(negedge clk) begin
        if (bus.load) load_total++;
        if (bus.err) err_total++;
        if (bus.load && bus.err) overlap_total++;
    end

    typedef struct {
        bit [95:0]   txt;
        int          len;
        int          loads;
        int          errs;
        logic [23:0] digits;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int actual, input int expected);
        n_chk++;
        if (actual != expected) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic int digits();
        return int'({2'b00, bus.hr1, bus.hr0, 1'b0, bus.min1, bus.min0,
                     1'b0, bus.sec1, bus.sec0});
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        bus.rxd = 1'b0;
        idle(BIT);
        for (int i = 0; i < 8; i++) begin
            bus.rxd = b[i];
            idle(BIT);
        end
        bus.rxd = stop_bit;
        idle(BIT);
        bus.rxd = 1'b1;
        idle(4);
    endtask

    task automatic send_str(input bit [95:0] txt, input int len);
        for (int i = 0; i < len; i++) begin
            send_frame(txt[8*(len-1-i) +: 8], 1'b1);
        end
    endtask

    initial begin
        int l0;
        int e0;

        vecs[0] = '{"12:34:56\r",   9,  1, 0, 24'h123456};
        vecs[1] = '{"24",           2,  0, 1, 24'h123456};
        vecs[2] = '{"00:00:00\n",   9,  1, 0, 24'h000000};
        vecs[3] = '{"23:59:59\r\n", 10, 1, 0, 24'h235959};
        vecs[4] = '{"7",            1,  0, 1, 24'h235959};
        vecs[5] = '{"09:5A",        5,  0, 1, 24'h235959};
        vecs[6] = '{"00:6",         4,  0, 1, 24'h235959};
        vecs[7] = '{"\r\n\r",       3,  0, 0, 24'h235959};

        bus.rxd = 1'b1;
        rst = 1'b0;
        idle(3);
        check("rst_digits", digits(), 0);
        check("rst_load", int'(bus.load), 0);
        check("rst_err", int'(bus.err), 0);
        check("rst_busy", int'(bus.busy), 0);
        rst = 1'b1;
        idle(10);
        check("post_rst_busy", int'(bus.busy), 0);

        for (int i = 0; i < 8; i++) begin
            l0 = load_total;
            e0 = err_total;
            send_str(vecs[i].txt, vecs[i].len);
            idle(20);
            check($sformatf("v%0d_loads", i), load_total - l0, vecs[i].loads);
            check($sformatf("v%0d_errs", i), err_total - e0, vecs[i].errs);
            check($sformatf("v%0d_digits", i), digits(), int'(vecs[i].digits));
            check($sformatf("v%0d_busy", i), int'(bus.busy), 0);
        end

        // Framing error in the middle of a string aborts it.
        l0 = load_total;
        e0 = err_total;
        send_str("01:0", 4);
        check("fe_busy_partial", int'(bus.busy), 1);
        send_frame(8'h35, 1'b0);
        idle(20);
        check("fe_errs", err_total - e0, 1);
        check("fe_loads", load_total - l0, 0);
        check("fe_busy", int'(bus.busy), 0);
        check("fe_digits_kept", digits(), 24'h235959);
        l0 = load_total;
        e0 = err_total;
        send_str("01:02:03\n", 9);
        idle(20);
        check("fe_reload_loads", load_total - l0, 1);
        check("fe_reload_errs", err_total - e0, 0);
        check("fe_reload_digits", digits(), 24'h010203);

        // Short low glitch: shorter than half a bit, must be ignored.
        l0 = load_total;
        e0 = err_total;
        bus.rxd = 1'b0;
        idle(3 * BAUD);
        bus.rxd = 1'b1;
        idle(2 * BIT);
        check("glitch_loads", load_total - l0, 0);
        check("glitch_errs", err_total - e0, 0);
        check("glitch_busy", int'(bus.busy), 0);

        // Break: line held low for 20 bit times gives exactly one err.
        bus.rxd = 1'b0;
        idle(20 * BIT);
        check("break_errs", err_total - e0, 1);
        check("break_busy_low", int'(bus.busy), 1);
        bus.rxd = 1'b1;
        idle(20);
        check("break_busy_after", int'(bus.busy), 0);
        l0 = load_total;
        e0 = err_total;
        send_str("07:08:09\r", 9);
        idle(20);
        check("break_reload_loads", load_total - l0, 1);
        check("break_reload_errs", err_total - e0, 0);
        check("break_reload_digits", digits(), 24'h070809);

        // Reset in the middle of a string.
        send_str("12:34:56\r", 9);
        idle(20);
        check("mr_pre_digits", digits(), 24'h123456);
        send_str("12:3", 4);
        check("mr_busy_partial", int'(bus.busy), 1);
        rst = 1'b0;
        idle(3);
        check("mr_rst_digits", digits(), 0);
        check("mr_rst_busy", int'(bus.busy), 0);
        rst = 1'b1;
        idle(10);
        check("mr_post_digits", digits(), 0);
        check("mr_post_busy", int'(bus.busy), 0);
        l0 = load_total;
        e0 = err_total;
        send_str("00:00:07\r", 9);
        idle(20);
        check("mr_reload_loads", load_total - l0, 1);
        check("mr_reload_errs", err_total - e0, 0);
        check("mr_reload_digits", digits(), 24'h000007);

        check("load_err_overlap", overlap_total, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
